// File: rtl/cntr_defs.sv
// Shared definitions for the up/down counter: state codes and command priority encoding.
package cntr_defs;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_INC     = 3'b010,
        ST_INC2    = 3'b011,
        ST_DEC     = 3'b100,
        ST_DEC2    = 3'b101,
        ST_HOLD    = 3'b110,
        ST_ILLEGAL = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_DEC  = 3'd1,
        CMD_INC  = 3'd2,
        CMD_LOAD = 3'd3,
        CMD_CLR  = 3'd4
    } cmd_e;

    // Highest-priority command wins: clr > load > inc > dec.
    function automatic cmd_e cmd_decode(input logic clr, input logic load,
                                        input logic inc, input logic dec);
        if (clr)       return CMD_CLR;
        else if (load) return CMD_LOAD;
        else if (inc)  return CMD_INC;
        else if (dec)  return CMD_DEC;
        else           return CMD_NONE;
    endfunction

endpackage

// File: rtl/cla_n.sv
// Parametrised carry-lookahead adder: s = a + b + ci, co = carry out. Purely combinational.
module cla_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded as a flat sum of generate terms gated by the propagate chain.
    always_comb begin
        logic acc;
        logic pp;
        acc  = 1'b0;
        pp   = 1'b1;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= WIDTH; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i] = acc | (pp & ci);
        end
    end

    assign s  = p ^ c[WIDTH-1:0];
    assign co = c[WIDTH];

endmodule

// File: rtl/cntr_ud_n.sv
// Registered up/down counter with load/clear/hold, terminal-count and wrap flags; 1-cycle command-to-output.
// Define CNTR_UD_SAT_EN to clamp at 0 / 2^WIDTH-1 instead of wrapping.
module cntr_ud_n
    import cntr_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       state,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             wrap_q, wrap_d;
    cmd_e             cmd;
    logic             sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             co;

    assign cmd = cmd_decode(clr, load, inc, dec);

    always_comb begin
        state_d = ST_HOLD;
        if (state_q == ST_ILLEGAL) begin
            state_d = ST_IDLE;
        end else begin
            case (cmd)
                CMD_CLR:  state_d = ST_IDLE;
                CMD_LOAD: state_d = ST_LOAD;
                CMD_INC:  state_d = (state_q == ST_INC) ? ST_INC2 : ST_INC;
                CMD_DEC:  state_d = (state_q == ST_DEC) ? ST_DEC2 : ST_DEC;
                default:  state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_HOLD;
            endcase
        end
    end

    // Subtract shares the adder: d + ~STEP + 1, where a missing carry means borrow.
    assign sub   = (state_d == ST_DEC) || (state_d == ST_DEC2);
    assign add_b = sub ? ~STEP_V : STEP_V;

    cla_n #(.WIDTH(WIDTH)) u_add (
        .a  (d_q),
        .b  (add_b),
        .ci (sub),
        .s  (sum),
        .co (co)
    );

    always_comb begin
        d_d    = d_q;
        wrap_d = 1'b0;
        case (state_d)
            ST_IDLE: d_d = '0;
            ST_LOAD: d_d = d_in;
            ST_INC, ST_INC2: begin
                wrap_d = co;
`ifdef CNTR_UD_SAT_EN
                d_d = co ? '1 : sum;
`else
                d_d = sum;
`endif
            end
            ST_DEC, ST_DEC2: begin
                wrap_d = ~co;
`ifdef CNTR_UD_SAT_EN
                d_d = co ? sum : '0;
`else
                d_d = sum;
`endif
            end
            default: d_d = d_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        tc = 1'b0;
        case (state_q)
            ST_INC, ST_INC2: tc = (d_q == '1);
            ST_DEC, ST_DEC2: tc = (d_q == '0);
            default:         tc = 1'b0;
        endcase
    end

    assign d_out = d_q;
    assign state = state_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_cntr_ud_n.sv
// Directed bench for cntr_ud_n across four parameter sets; expected values are hand-computed.
module tb_cntr_ud_n;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8, STEP=1
    logic       a_clr, a_load, a_inc, a_dec, a_tc, a_wrap;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_st;
    // WIDTH=8, STEP=3
    logic       b_clr, b_load, b_inc, b_dec, b_tc, b_wrap;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_st;
    // WIDTH=4, STEP=1
    logic       c_clr, c_load, c_inc, c_dec, c_tc, c_wrap;
    logic [3:0] c_din, c_dout;
    logic [2:0] c_st;
    // WIDTH=4, STEP=2
    logic       e_clr, e_load, e_inc, e_dec, e_tc, e_wrap;
    logic [3:0] e_din, e_dout;
    logic [2:0] e_st;

    cntr_ud_n #(.WIDTH(8), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .inc(a_inc), .dec(a_dec),
        .d_in(a_din), .d_out(a_dout), .state(a_st), .tc(a_tc), .wrap(a_wrap));
    cntr_ud_n #(.WIDTH(8), .STEP(3)) dut_b (
        .clk(clk), .reset(reset), .clr(b_clr), .load(b_load), .inc(b_inc), .dec(b_dec),
        .d_in(b_din), .d_out(b_dout), .state(b_st), .tc(b_tc), .wrap(b_wrap));
    cntr_ud_n #(.WIDTH(4), .STEP(1)) dut_c (
        .clk(clk), .reset(reset), .clr(c_clr), .load(c_load), .inc(c_inc), .dec(c_dec),
        .d_in(c_din), .d_out(c_dout), .state(c_st), .tc(c_tc), .wrap(c_wrap));
    cntr_ud_n #(.WIDTH(4), .STEP(2)) dut_e (
        .clk(clk), .reset(reset), .clr(e_clr), .load(e_load), .inc(e_inc), .dec(e_dec),
        .d_in(e_din), .d_out(e_dout), .state(e_st), .tc(e_tc), .wrap(e_wrap));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks d_out, state, tc, wrap of dut_a in one call.
    task automatic chk_a(input string tag, input int d, input int s, input int t, input int w);
        chk({tag, ".d"},    32'(a_dout), d);
        chk({tag, ".st"},   32'(a_st),   s);
        chk({tag, ".tc"},   32'(a_tc),   t);
        chk({tag, ".wrap"}, 32'(a_wrap), w);
    endtask

    initial begin
        reset = 1'b1;
        {a_clr, a_load, a_inc, a_dec} = '0; a_din = '0;
        {b_clr, b_load, b_inc, b_dec} = '0; b_din = '0;
        {c_clr, c_load, c_inc, c_dec} = '0; c_din = '0;
        {e_clr, e_load, e_inc, e_dec} = '0; e_din = '0;
        step();
        step();
        reset = 1'b0;
        chk_a("reset", 'h00, 0, 0, 0);

        // Load 0xFD then count up through the wrap.
        a_load = 1'b1; a_din = 8'hFD;
        step(); chk_a("ld_fd", 'hFD, 1, 0, 0);
        a_load = 1'b0; a_inc = 1'b1;
        step(); chk_a("inc1", 'hFE, 2, 0, 0);
        step(); chk_a("inc2", 'hFF, 3, 1, 0);
        step(); chk_a("inc3", 'h00, 2, 0, 1);
        step(); chk_a("inc4", 'h01, 3, 0, 0);
        a_inc = 1'b0;

        // Asynchronous reset in the middle of an INC run at 0x37.
        a_load = 1'b1; a_din = 8'h36;
        step(); chk_a("ld_36", 'h36, 1, 0, 0);
        a_load = 1'b0; a_inc = 1'b1;
        step(); chk_a("inc_37", 'h37, 2, 0, 0);
        #2 reset = 1'b1;
        #1 chk_a("arst", 'h00, 0, 0, 0);
        a_inc = 1'b0;
        step();
        reset = 1'b0;

        // Priority: clr over load over inc, then load over inc, then hold.
        a_clr = 1'b1; a_load = 1'b1; a_inc = 1'b1; a_din = 8'h55;
        step(); chk_a("prio_clr", 'h00, 0, 0, 0);
        a_clr = 1'b0; a_din = 8'h20;
        step(); chk_a("prio_ld", 'h20, 1, 0, 0);
        a_load = 1'b0; a_inc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold.d",  32'(a_dout), 'h20);
            chk("hold.st", 32'(a_st),   6);
        end

        // Illegal state recovers to IDLE with d_out cleared.
        force dut_a.state_q = cntr_defs::ST_ILLEGAL;
        #1 chk("ill.st", 32'(a_st), 7);
        release dut_a.state_q;
        step(); chk_a("ill_rec", 'h00, 0, 0, 0);

        // STEP=3 decrement across zero.
        b_load = 1'b1; b_din = 8'h04;
        step();
        chk("b_ld.d", 32'(b_dout), 'h04);
        b_load = 1'b0; b_dec = 1'b1;
        step();
        chk("b_dec1.d",  32'(b_dout), 'h01);
        chk("b_dec1.st", 32'(b_st),   4);
        chk("b_dec1.w",  32'(b_wrap), 0);
        step();
        chk("b_dec2.d",  32'(b_dout), 'hFE);
        chk("b_dec2.st", 32'(b_st),   5);
        chk("b_dec2.w",  32'(b_wrap), 1);
        b_dec = 1'b0;

        // WIDTH=4 increment at the top.
        c_load = 1'b1; c_din = 4'hF;
        step();
        chk("c_ld.d", 32'(c_dout), 'hF);
        c_load = 1'b0; c_inc = 1'b1;
        step();
`ifdef CNTR_UD_SAT_EN
        chk("c_inc1.d",  32'(c_dout), 'hF);
        chk("c_inc1.tc", 32'(c_tc),   1);
`else
        chk("c_inc1.d",  32'(c_dout), 'h0);
        chk("c_inc1.tc", 32'(c_tc),   0);
`endif
        chk("c_inc1.w",  32'(c_wrap), 1);
        chk("c_inc1.st", 32'(c_st),   2);
        step();
`ifdef CNTR_UD_SAT_EN
        chk("c_inc2.d", 32'(c_dout), 'hF);
        chk("c_inc2.w", 32'(c_wrap), 1);
`else
        chk("c_inc2.d", 32'(c_dout), 'h1);
        chk("c_inc2.w", 32'(c_wrap), 0);
`endif
        chk("c_inc2.st", 32'(c_st), 3);
        c_inc = 1'b0;

        // WIDTH=4, STEP=2 decrement from 1.
        e_load = 1'b1; e_din = 4'h1;
        step();
        chk("e_ld.d", 32'(e_dout), 'h1);
        e_load = 1'b0; e_dec = 1'b1;
        step();
`ifdef CNTR_UD_SAT_EN
        chk("e_dec1.d",  32'(e_dout), 'h0);
        chk("e_dec1.tc", 32'(e_tc),   1);
`else
        chk("e_dec1.d",  32'(e_dout), 'hF);
        chk("e_dec1.tc", 32'(e_tc),   0);
`endif
        chk("e_dec1.w",  32'(e_wrap), 1);
        chk("e_dec1.st", 32'(e_st),   4);
        step();
`ifdef CNTR_UD_SAT_EN
        chk("e_dec2.d", 32'(e_dout), 'h0);
        chk("e_dec2.w", 32'(e_wrap), 1);
`else
        chk("e_dec2.d", 32'(e_dout), 'hD);
        chk("e_dec2.w", 32'(e_wrap), 0);
`endif
        chk("e_dec2.st", 32'(e_st), 5);
        e_dec = 1'b0;
        step();
        chk("e_hold.st", 32'(e_st),   6);
        chk("e_hold.w",  32'(e_wrap), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
